// File: rtl/rv32_pkg.sv
// rv32_pkg: shared constants for the RV32 hazard unit.
//   REG_AW       default register-address width
//   FWD_*        E-stage operand select encodings
//   mdu_state_e  MDU occupancy FSM encodings
package rv32_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage result

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_timer.sv
// mdu_timer: holds E for a fixed MDU latency.
//   clk, rst  clock / synchronous active-high reset
//   start     MDU op sitting in E (held high while it is there)
//   busy      E must stall this cycle (includes the start cycle itself)
//   done      MDU result valid this cycle
// E is held MDU_LATENCY cycles in total: the start cycle, MDU_LATENCY-2
// cycles in BUSY, then one DONE cycle.
module mdu_timer #(
    parameter int MDU_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);
    import rv32_pkg::*;

    localparam int              CW       = $clog2(MDU_LATENCY);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(MDU_LATENCY - 2);

    mdu_state_e     state;
    logic [CW-1:0]  cnt;

    // cnt counts the BUSY cycles still owed. The last BUSY cycle is the one
    // seen with cnt==1; it moves to DONE while cnt lands on 0. With the
    // minimum latency of 2 there are no BUSY cycles, so IDLE goes straight
    // to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        cnt   <= CNT_LOAD;
                        state <= (MDU_LATENCY == 2) ? MDU_DONE : MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1))
                        state <= MDU_DONE;
                end
                MDU_DONE: state <= MDU_IDLE;  // same op still in E; start ignored
                default:  state <= MDU_IDLE;
            endcase
        end
    end

    // Start cycle already stalls so the op cannot slip out of E.
    assign busy = (state == MDU_BUSY) || ((state == MDU_IDLE) && start);
    assign done = (state == MDU_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enables/flushes and E-stage forward selects.
//   clk, rst                       clock / synchronous active-high reset
//   rs1_d_i, rs2_d_i               sources of instruction in D
//   rs1_e_i, rs2_e_i, rd_e_i       sources / dest of instruction in E
//   load_e_i                       E holds a load
//   pc_src_e_i                     taken branch/jump resolved in E
//   mdu_start_e_i                  E holds an MDU op
//   rd_m_i, reg_write_m_i          M-stage writeback
//   rd_w_i, reg_write_w_i          W-stage writeback
//   enable_f_o/_d_o/_e_o           PC, F/D, D/E register enables
//   flush_d_o/_e_o/_m_o            F/D, D/E, E/M synchronous clears
//   fwd_a_o, fwd_b_o               operand selects (00 RF, 01 W, 10 M)
//   mdu_busy_o, mdu_done_o         MDU occupying E / result valid
module hazard_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic [REG_AW-1:0] rs1_e_i,
    input  logic [REG_AW-1:0] rs2_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic              load_e_i,
    input  logic              pc_src_e_i,
    input  logic              mdu_start_e_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_w_i,
    output logic              enable_f_o,
    output logic              enable_d_o,
    output logic              enable_e_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              flush_m_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              mdu_busy_o,
    output logic              mdu_done_o
);
    import rv32_pkg::*;

    logic mdu_busy;
    logic mdu_done;
    logic lw_stall;

    mdu_timer #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_timer (
        .clk   (clk),
        .rst   (rst),
        .start (mdu_start_e_i),
        .busy  (mdu_busy),
        .done  (mdu_done)
    );

    // M is younger than W, so its value wins. x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs))
            return FWD_MEM;
        else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a_o = fwd_sel(rs1_e_i);
    assign fwd_b_o = fwd_sel(rs2_e_i);

    assign lw_stall = load_e_i && (rd_e_i != '0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

    always_comb begin
        enable_f_o = 1'b1;
        enable_d_o = 1'b1;
        enable_e_o = 1'b1;
        flush_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        flush_m_o  = 1'b0;
        if (mdu_busy) begin
            // Freeze F/D/E and push bubbles into M while the MDU runs.
            enable_f_o = 1'b0;
            enable_d_o = 1'b0;
            enable_e_o = 1'b0;
            flush_m_o  = 1'b1;
        end else begin
            // A redirect squashes the dependent instruction anyway, so the
            // load-use stall is dropped when both fire together.
            enable_f_o = !(lw_stall && !pc_src_e_i);
            enable_d_o = !(lw_stall && !pc_src_e_i);
            flush_d_o  = pc_src_e_i;
            flush_e_o  = pc_src_e_i || lw_stall;
        end
    end

    assign mdu_busy_o = mdu_busy;
    assign mdu_done_o = mdu_done;

endmodule
